memram_bank: RTL and testbench

Parametrised single-clock memory bank: the next generation of the team's simple RAM. It adds separate read and write ports, per-lane write masking, a registered read with a valid strobe, and a hardware clear sequencer that zeroes the array after reset or on request. The bank sits between the datapath and the processor's load/store logic, which must observe `busy` before issuing accesses.

---
 rtl/memram_bank.sv | 151 +++++++++++++++
 tb/tb_memram_bank.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/memram_bank.sv
// memram_bank: single-clock memory bank with separate read/write ports,
// per-lane write masking, registered read with valid strobe, and a hardware
// clear sequencer that zeroes the whole array after reset or on request.
// Optional feature macro: MEMRAM_BANK_BYPASS_EN
//   defined     -> same-address read/write collisions forward the new data
//                  on the masked lanes (write-first, per lane)
//   not defined -> collisions return the pre-write word (read-first)
module memram_bank #(
    parameter int address_length = 6,
    parameter int data_length    = 16,
    parameter int lane_length    = 8
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                clear,
    input  logic                                wren,
    input  logic [address_length-1:0]           wr_address,
    input  logic [data_length/lane_length-1:0]  wr_mask,
    input  logic [data_length-1:0]              write_data,
    input  logic                                rden,
    input  logic [address_length-1:0]           rd_address,
    output logic [data_length-1:0]              read_data,
    output logic                                read_valid,
    output logic                                busy
);

    localparam int lanes = data_length / lane_length;
    localparam int depth = 2 ** address_length;
    localparam logic [address_length-1:0] last_address = '1;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

    state_t                    state;
    state_t                    state_nxt;
    logic [address_length-1:0] counter;
    logic [address_length-1:0] counter_nxt;

    // Array write port, shared by the clear sweep and the user write path.
    logic                      mem_we;
    logic [address_length-1:0] mem_waddr;
    logic [data_length-1:0]    mem_wdata;
    logic [lanes-1:0]          mem_wmask;

    logic                      rd_accept;
    logic [data_length-1:0]    rd_word;

    logic [data_length-1:0]    mem [depth];

    // State and sweep-counter register; reset restarts the sweep at address 0.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= CLEAR;
            counter <= '0;
        end else begin
            state   <= state_nxt;
            counter <= counter_nxt;
        end
    end

    // Next-state logic and write-port steering for sweep versus user access.
    // NOTE: every output of this block is defaulted first so no path leaves a
    // signal unassigned and no latch is inferred.
    always_comb begin
        state_nxt   = state;
        counter_nxt = counter;
        mem_we      = 1'b0;
        mem_waddr   = wr_address;
        mem_wdata   = write_data;
        mem_wmask   = wr_mask;
        rd_accept   = 1'b0;
        case (state)
            CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = counter;
                mem_wdata = '0;
                mem_wmask = '1;
                if (clear) begin
                    counter_nxt = '0;
                end else begin
                    counter_nxt = counter + 1'b1;
                    if (counter == last_address) begin
                        state_nxt = IDLE;
                    end
                end
            end
            IDLE: begin
                if (clear) begin
                    state_nxt   = CLEAR;
                    counter_nxt = '0;
                end else begin
                    mem_we    = wren;
                    rd_accept = rden;
                end
            end
            default: begin
                state_nxt   = CLEAR;
                counter_nxt = '0;
            end
        endcase
    end

    assign busy = (state == CLEAR);

    // Lane-masked array write.
    // NOTE: the array has no reset; the post-reset sweep zeroes it instead,
    // which keeps it mappable onto plain RAM macros.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < lanes; i++) begin
                if (mem_wmask[i]) begin
                    mem[mem_waddr][i*lane_length +: lane_length] <=
                        mem_wdata[i*lane_length +: lane_length];
                end
            end
        end
    end

    // Word presented to the read register, with optional per-lane forwarding.
    always_comb begin
        rd_word = mem[rd_address];
`ifdef MEMRAM_BANK_BYPASS_EN
        if (mem_we && (mem_waddr == rd_address)) begin
            for (int i = 0; i < lanes; i++) begin
                if (mem_wmask[i]) begin
                    rd_word[i*lane_length +: lane_length] =
                        mem_wdata[i*lane_length +: lane_length];
                end
            end
        end
`endif
    end

    // Registered read port; data holds whenever no read is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            read_data  <= '0;
            read_valid <= 1'b0;
        end else begin
            read_valid <= rd_accept;
            if (rd_accept) begin
                read_data <= rd_word;
            end
        end
    end

endmodule

// File: tb/tb_memram_bank.sv
// tb_memram_bank: self-checking bench for memram_bank (default parameters).
// Table-driven directed vectors, randomized traffic against a word-array
// reference model, and hand-written clear/reset sequences.
// Honours MEMRAM_BANK_BYPASS_EN for collision expectations.
module tb_memram_bank;

    localparam int AW    = 6;
    localparam int DW    = 16;
    localparam int LW    = 8;
    localparam int LANES = DW / LW;
    localparam int DEPTH = 2 ** AW;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             clear;
    logic             wren;
    logic [AW-1:0]    wr_address;
    logic [LANES-1:0] wr_mask;
    logic [DW-1:0]    write_data;
    logic             rden;
    logic [AW-1:0]    rd_address;
    logic [DW-1:0]    read_data;
    logic             read_valid;
    logic             busy;

    memram_bank #(
        .address_length(AW),
        .data_length   (DW),
        .lane_length   (LW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .wren      (wren),
        .wr_address(wr_address),
        .wr_mask   (wr_mask),
        .write_data(write_data),
        .rden      (rden),
        .rd_address(rd_address),
        .read_data (read_data),
        .read_valid(read_valid),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: array contents and the last value read_data should hold.
    logic [DW-1:0] model_mem [DEPTH];
    logic [DW-1:0] hold_data;

    typedef struct {
        logic             wren;
        logic [AW-1:0]    wa;
        logic [LANES-1:0] m;
        logic [DW-1:0]    wd;
        logic             rden;
        logic [AW-1:0]    ra;
        logic             ev;
        logic [DW-1:0]    ed;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        clear      = 1'b0;
        wren       = 1'b0;
        rden       = 1'b0;
        wr_address = '0;
        wr_mask    = '0;
        write_data = '0;
        rd_address = '0;
    endtask

    // One IDLE-state access; model predicts outputs, then commits the write.
    task automatic do_op(input logic we, input logic [AW-1:0] wa, input logic [LANES-1:0] m,
                         input logic [DW-1:0] wd, input logic re, input logic [AW-1:0] ra,
                         output logic exp_valid, output logic [DW-1:0] exp_data);
        logic [DW-1:0] word;
        word = model_mem[ra];
`ifdef MEMRAM_BANK_BYPASS_EN
        if (we && wa == ra) begin
            for (int l = 0; l < LANES; l++) begin
                if (m[l]) word[l*LW +: LW] = wd[l*LW +: LW];
            end
        end
`endif
        exp_valid = re;
        exp_data  = re ? word : hold_data;
        hold_data = exp_data;
        if (we) begin
            for (int l = 0; l < LANES; l++) begin
                if (m[l]) model_mem[wa][l*LW +: LW] = wd[l*LW +: LW];
            end
        end
        wren = we; wr_address = wa; wr_mask = m; write_data = wd;
        rden = re; rd_address = ra;
        step();
        idle_inputs();
    endtask

    // Drives junk traffic while busy, checks it is ignored, counts busy edges.
    task automatic run_busy(input string tag);
        int n = 0;
        while (busy === 1'b1 && n < 200) begin
            wren       = 1'($urandom);
            rden       = 1'($urandom);
            wr_address = AW'($urandom);
            rd_address = AW'($urandom);
            wr_mask    = LANES'($urandom);
            write_data = DW'($urandom) | 16'h0101;
            step();
            n++;
            check({tag, " valid while busy"}, 32'(read_valid), 32'd0);
            check({tag, " data hold while busy"}, 32'(read_data), 32'(hold_data));
        end
        idle_inputs();
        check({tag, " busy edges"}, n, DEPTH);
        for (int a = 0; a < DEPTH; a++) model_mem[a] = '0;
    endtask

    task automatic read_all_zero(input string tag);
        logic          ev;
        logic [DW-1:0] ed;
        for (int a = 0; a < DEPTH; a++) begin
            do_op(1'b0, '0, '0, '0, 1'b1, AW'(a), ev, ed);
            check({tag, " valid"}, 32'(read_valid), 32'd1);
            check({tag, " data"}, 32'(read_data), 32'd0);
        end
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("clear raises busy", 32'(busy), 32'd1);
    endtask

    initial begin
        logic          ev;
        logic [DW-1:0] ed;

        vecs[0] = '{1'b1, 6'd5,  2'b11, 16'hA55A, 1'b0, 6'd0,  1'b0, 16'h0000};
        vecs[1] = '{1'b1, 6'd5,  2'b01, 16'h1234, 1'b0, 6'd0,  1'b0, 16'h0000};
        vecs[2] = '{1'b0, 6'd0,  2'b00, 16'h0000, 1'b1, 6'd5,  1'b1, 16'hA534};
        vecs[3] = '{1'b0, 6'd0,  2'b00, 16'h0000, 1'b0, 6'd0,  1'b0, 16'hA534};
        vecs[4] = '{1'b1, 6'd7,  2'b00, 16'hFFFF, 1'b1, 6'd7,  1'b1, 16'h0000};
`ifdef MEMRAM_BANK_BYPASS_EN
        vecs[5] = '{1'b1, 6'd9,  2'b11, 16'hBEEF, 1'b1, 6'd9,  1'b1, 16'hBEEF};
        vecs[7] = '{1'b1, 6'd10, 2'b01, 16'hBEEF, 1'b1, 6'd10, 1'b1, 16'h00EF};
`else
        vecs[5] = '{1'b1, 6'd9,  2'b11, 16'hBEEF, 1'b1, 6'd9,  1'b1, 16'h0000};
        vecs[7] = '{1'b1, 6'd10, 2'b01, 16'hBEEF, 1'b1, 6'd10, 1'b1, 16'h0000};
`endif
        vecs[6] = '{1'b0, 6'd0,  2'b00, 16'h0000, 1'b1, 6'd9,  1'b1, 16'hBEEF};
        vecs[8] = '{1'b0, 6'd0,  2'b00, 16'h0000, 1'b1, 6'd10, 1'b1, 16'h00EF};

        // Reset state and power-up sweep.
        idle_inputs();
        hold_data = '0;
        rst_n = 1'b0;
        #2;
        check("reset read_data", 32'(read_data), 32'd0);
        check("reset read_valid", 32'(read_valid), 32'd0);
        check("reset busy", 32'(busy), 32'd1);
        step();
        step();
        rst_n = 1'b1;
        run_busy("power-up");
        read_all_zero("post-reset read");

        // Directed table: masking, hold, collisions.
        for (int v = 0; v < 9; v++) begin
            do_op(vecs[v].wren, vecs[v].wa, vecs[v].m, vecs[v].wd,
                  vecs[v].rden, vecs[v].ra, ev, ed);
            check($sformatf("vec%0d valid", v), 32'(read_valid), 32'(vecs[v].ev));
            check($sformatf("vec%0d data", v), 32'(read_data), 32'(vecs[v].ed));
        end

        // Random traffic on a small address window to provoke collisions.
        for (int t = 0; t < 400; t++) begin
            do_op(1'($urandom), AW'($urandom_range(0, 7)), LANES'($urandom), DW'($urandom),
                  1'($urandom), AW'($urandom_range(0, 7)), ev, ed);
            check("random valid", 32'(read_valid), 32'(ev));
            check("random data", 32'(read_data), 32'(ed));
        end

        // Fill with ones, clear from IDLE, accesses ignored while busy.
        for (int a = 0; a < DEPTH; a++) begin
            do_op(1'b1, AW'(a), '1, 16'hFFFF, 1'b0, '0, ev, ed);
        end
        do_op(1'b0, '0, '0, '0, 1'b1, 6'd33, ev, ed);
        check("filled read", 32'(read_data), 32'hFFFF);
        pulse_clear();
        run_busy("clear sweep");
        read_all_zero("post-clear read");

        // Restart the sweep with clear at counter 40.
        do_op(1'b1, 6'd3, '1, 16'h5A5A, 1'b0, '0, ev, ed);
        do_op(1'b0, '0, '0, '0, 1'b1, 6'd3, ev, ed);
        check("pre-restart read", 32'(read_data), 32'h5A5A);
        pulse_clear();
        for (int k = 0; k < 40; k++) begin
            step();
            check("busy before restart", 32'(busy), 32'd1);
        end
        clear = 1'b1;
        step();
        clear = 1'b0;
        run_busy("restarted sweep");

        // Reset pulse at counter 20: outputs clear asynchronously.
        do_op(1'b1, 6'd3, '1, 16'h5A5A, 1'b0, '0, ev, ed);
        do_op(1'b0, '0, '0, '0, 1'b1, 6'd3, ev, ed);
        check("pre-reset read", 32'(read_data), 32'h5A5A);
        pulse_clear();
        repeat (20) step();
        rst_n = 1'b0;
        #1;
        check("async reset read_data", 32'(read_data), 32'd0);
        check("async reset read_valid", 32'(read_valid), 32'd0);
        check("async reset busy", 32'(busy), 32'd1);
        hold_data = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_busy("reset sweep");
        read_all_zero("final read");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
